stack_alu_cpu: RTL

- Parametrised successor to the 4-bit stack processor: a WIDTH-bit data stack of DEPTH entries with an integrated ALU, driven by a valid/ready instruction port.
- Sits between the chip IO wrapper (which packs opcode/operand from pins) and a latched output word.
- Adds arithmetic/logic ops, carry, and stack overflow/underflow detection.

---
 rtl/stack_alu_pkg.sv | 63 ++++++
 rtl/stack_regfile.sv | 118 +++++++++++
 rtl/stack_alu_cpu.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/stack_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stack_alu_pkg
//  Description : Shared opcode, FSM-state, stack-command and per-opcode
//                operand-requirement constants for stack_alu_cpu.
//                Optional ROT support: define STACK_ALU_CPU_ROT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package stack_alu_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_PUSH = 4'h1;
   localparam logic [3:0] OP_POP  = 4'h2;
   localparam logic [3:0] OP_OUT  = 4'h3;
   localparam logic [3:0] OP_ROT  = 4'h4;
   localparam logic [3:0] OP_SWAP = 4'h5;
   localparam logic [3:0] OP_OVER = 4'h6;
   localparam logic [3:0] OP_DUP  = 4'h7;
   localparam logic [3:0] OP_ADD  = 4'h8;
   localparam logic [3:0] OP_SUB  = 4'h9;
   localparam logic [3:0] OP_AND  = 4'hA;
   localparam logic [3:0] OP_OR   = 4'hB;
   localparam logic [3:0] OP_XOR  = 4'hC;
   localparam logic [3:0] OP_NOT  = 4'hD;
   localparam logic [3:0] OP_INC  = 4'hE;
   localparam logic [3:0] OP_DEC  = 4'hF;

   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_EXEC  = 1'b1
   } state_e;

   // Single-cycle stack write commands understood by stack_regfile.
   typedef enum logic [2:0] {
      CMD_NONE      = 3'd0,
      CMD_PUSH      = 3'd1,
      CMD_POP       = 3'd2,
      CMD_POP2_PUSH = 3'd3,
      CMD_REPLACE   = 3'd4,
      CMD_SWAP      = 3'd5,
      CMD_ROT       = 3'd6
   } cmd_e;

`ifdef STACK_ALU_CPU_ROT_EN
   localparam logic [1:0] ROT_MIN_DEPTH = 2'd3;
`else
   localparam logic [1:0] ROT_MIN_DEPTH = 2'd0;
`endif

   // Minimum stack occupancy each opcode needs, indexed by opcode.
   localparam logic [1:0] MIN_DEPTH [16] = '{
      2'd0, 2'd0, 2'd1, 2'd1, ROT_MIN_DEPTH, 2'd2, 2'd2, 2'd1,
      2'd2, 2'd2, 2'd2, 2'd2, 2'd2,          2'd1, 2'd1, 2'd1
   };

   // Net change in occupancy each opcode causes, indexed by opcode.
   localparam int NET_PUSH [16] = '{
       0,  1, -1,  0,  0,  0,  1,  1,
      -1, -1, -1, -1, -1,  0,  0,  0
   };

endpackage
`default_nettype wire

// File: rtl/stack_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : stack_regfile
//  Description : WIDTH x DEPTH data stack with occupancy pointer, top/second
//                read ports and single-cycle write commands. The caller
//                guarantees each command is legal for the current depth.
//                Third-entry port exists only with STACK_ALU_CPU_ROT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_regfile
   import stack_alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  cmd_e                         cmd,
   input  logic [WIDTH-1:0]             wdata,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic [WIDTH-1:0]             top,
   output logic [WIDTH-1:0]             second
`ifdef STACK_ALU_CPU_ROT_EN
  ,output logic [WIDTH-1:0]             third
`endif
);

   localparam int PW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    depth_q;
   logic [PW-1:0]    depth_d;
   logic [PW-1:0]    idx_t;
   logic [PW-1:0]    idx_s;

   assign idx_t = depth_q - PW'(1);
   assign idx_s = depth_q - PW'(2);
   assign depth = depth_q;

   // Top and second read ports; an out-of-range index simply reads zero.
   always_comb begin
      top    = '0;
      second = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (PW'(i) == idx_t) top    = mem_q[i];
         if (PW'(i) == idx_s) second = mem_q[i];
      end
   end

`ifdef STACK_ALU_CPU_ROT_EN
   logic [PW-1:0] idx_3;
   assign idx_3 = depth_q - PW'(3);

   // Third-entry read port used only by ROT.
   always_comb begin
      third = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (PW'(i) == idx_3) third = mem_q[i];
      end
   end
`endif

   // Next-state of the array and pointer for the requested command.
   always_comb begin
      mem_d   = mem_q;
      depth_d = depth_q;
      case (cmd)
         CMD_PUSH: begin
            for (int i = 0; i < DEPTH; i++)
               if (PW'(i) == depth_q) mem_d[i] = wdata;
            depth_d = depth_q + PW'(1);
         end
         CMD_POP: begin
            depth_d = depth_q - PW'(1);
         end
         CMD_POP2_PUSH: begin
            for (int i = 0; i < DEPTH; i++)
               if (PW'(i) == idx_s) mem_d[i] = wdata;
            depth_d = depth_q - PW'(1);
         end
         CMD_REPLACE: begin
            for (int i = 0; i < DEPTH; i++)
               if (PW'(i) == idx_t) mem_d[i] = wdata;
         end
         CMD_SWAP: begin
            for (int i = 0; i < DEPTH; i++) begin
               if (PW'(i) == idx_t) mem_d[i] = second;
               if (PW'(i) == idx_s) mem_d[i] = top;
            end
         end
`ifdef STACK_ALU_CPU_ROT_EN
         CMD_ROT: begin
            for (int i = 0; i < DEPTH; i++) begin
               if (PW'(i) == idx_t) mem_d[i] = third;
               if (PW'(i) == idx_s) mem_d[i] = top;
               if (PW'(i) == idx_3) mem_d[i] = second;
            end
         end
`endif
         default: begin
         end
      endcase
   end

   // Stack storage and pointer registers, cleared on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         depth_q <= '0;
      end else begin
         mem_q   <= mem_d;
         depth_q <= depth_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/stack_alu_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : stack_alu_cpu
//  Description : Two-cycle FETCH/EXEC stack processor with integrated ALU,
//                carry flag, sticky over/underflow error and output latch.
//                Define STACK_ALU_CPU_ROT_EN to make opcode 4 a ROT.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_alu_cpu
   import stack_alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         instr_valid,
   output logic                         instr_ready,
   input  logic [3:0]                   opcode,
   input  logic [WIDTH-1:0]             operand,
   output logic [WIDTH-1:0]             out_word,
   output logic                         out_strobe,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         carry,
   output logic                         err
);

   localparam int PW = $clog2(DEPTH+1);

   state_e           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] operand_q, operand_d;
   logic [WIDTH-1:0] out_word_q, out_word_d;
   logic             out_strobe_q, out_strobe_d;
   logic             carry_q, carry_d;
   logic             err_q, err_d;

   cmd_e             cmd;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH:0]   wide;
   logic [WIDTH-1:0] top;
   logic [WIDTH-1:0] second;
   logic             underflow;
   logic             overflow;
`ifdef STACK_ALU_CPU_ROT_EN
   logic [WIDTH-1:0] third;
`endif

   stack_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .cmd    (cmd),
      .wdata  (wdata),
      .depth  (depth),
      .top    (top),
      .second (second)
`ifdef STACK_ALU_CPU_ROT_EN
     ,.third  (third)
`endif
   );

   assign underflow = depth < PW'(MIN_DEPTH[op_q]);
   assign overflow  = (NET_PUSH[op_q] > 0) && (depth == PW'(DEPTH));

   // FSM sequencing, decode and ALU; illegal-depth ops only raise err.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      operand_d    = operand_q;
      out_word_d   = out_word_q;
      out_strobe_d = 1'b0;
      carry_d      = carry_q;
      err_d        = err_q;
      cmd          = CMD_NONE;
      wdata        = '0;
      wide         = '0;
      instr_ready  = 1'b0;
      case (state_q)
         ST_FETCH: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               op_d      = opcode;
               operand_d = operand;
               state_d   = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            if (underflow || overflow) begin
               err_d = 1'b1;
            end else begin
               case (op_q)
                  OP_PUSH: begin cmd = CMD_PUSH; wdata = operand_q; end
                  OP_POP:  cmd = CMD_POP;
                  OP_OUT: begin
                     out_word_d   = top;
                     out_strobe_d = 1'b1;
                  end
`ifdef STACK_ALU_CPU_ROT_EN
                  OP_ROT:  cmd = CMD_ROT;
`endif
                  OP_SWAP: cmd = CMD_SWAP;
                  OP_OVER: begin cmd = CMD_PUSH; wdata = second; end
                  OP_DUP:  begin cmd = CMD_PUSH; wdata = top; end
                  OP_ADD: begin
                     wide    = {1'b0, second} + {1'b0, top};
                     cmd     = CMD_POP2_PUSH;
                     wdata   = wide[WIDTH-1:0];
                     carry_d = wide[WIDTH];
                  end
                  OP_SUB: begin
                     wide    = {1'b0, second} - {1'b0, top};
                     cmd     = CMD_POP2_PUSH;
                     wdata   = wide[WIDTH-1:0];
                     carry_d = wide[WIDTH];
                  end
                  OP_AND:  begin cmd = CMD_POP2_PUSH; wdata = second & top; end
                  OP_OR:   begin cmd = CMD_POP2_PUSH; wdata = second | top; end
                  OP_XOR:  begin cmd = CMD_POP2_PUSH; wdata = second ^ top; end
                  OP_NOT:  begin cmd = CMD_REPLACE;   wdata = ~top; end
                  OP_INC: begin
                     wide    = {1'b0, top} + (WIDTH+1)'(1);
                     cmd     = CMD_REPLACE;
                     wdata   = wide[WIDTH-1:0];
                     carry_d = wide[WIDTH];
                  end
                  OP_DEC: begin
                     wide    = {1'b0, top} - (WIDTH+1)'(1);
                     cmd     = CMD_REPLACE;
                     wdata   = wide[WIDTH-1:0];
                     carry_d = wide[WIDTH];
                  end
                  default: begin
                  end
               endcase
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // Control and flag registers; reset also aborts any op in EXEC.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_FETCH;
         op_q         <= OP_NOP;
         operand_q    <= '0;
         out_word_q   <= '0;
         out_strobe_q <= 1'b0;
         carry_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         operand_q    <= operand_d;
         out_word_q   <= out_word_d;
         out_strobe_q <= out_strobe_d;
         carry_q      <= carry_d;
         err_q        <= err_d;
      end
   end

   assign out_word   = out_word_q;
   assign out_strobe = out_strobe_q;
   assign carry      = carry_q;
   assign err        = err_q;

endmodule
`default_nettype wire
